// File: rtl/sha256_acc_top_if.sv
// rtl/sha256_acc_top_if.sv - bus and digest-output signal bundle for the SHA-256 accelerator
// Purpose: groups the write-only bus slave inputs and the digest word/address outputs.
// Signals:
//   chipselect   1  bus slave select
//   write        1  bus write strobe, qualified by chipselect
//   address      5  bus word address
//   writedata    32 bus write data
//   data_out     32 digest word currently presented
//   writeaddress 4  index (0..7) of the digest word on data_out
interface sha256_acc_top_if;
   logic        chipselect;
   logic        write;
   logic [4:0]  address;
   logic [31:0] writedata;
   logic [31:0] data_out;
   logic [3:0]  writeaddress;

   modport master (
      output chipselect, write, address, writedata,
      input  data_out, writeaddress
   );

   modport slave (
      input  chipselect, write, address, writedata,
      output data_out, writeaddress
   );
endinterface

// File: rtl/sha256_acc_top.sv
// rtl/sha256_acc_top.sv - SHA-256 single-block compression accelerator behind a write-only bus
// Purpose: stores sixteen message words, runs 64 rounds from the standard IV on a start
//          write, then streams the eight digest words out one per cycle.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    slave modport: chipselect/write/address/writedata in, data_out/writeaddress out
module sha256_acc_top #(
   parameter int NUM_WORDS  = 16,
   parameter int START_ADDR = 16
) (
   input logic             clk,
   input logic             reset,
   sha256_acc_top_if.slave bus
);

   localparam int AW = $clog2(NUM_WORDS);

   typedef enum logic [1:0] {IDLE, ROUND, FINAL, OUTPUT} state_t;

   localparam logic [31:0] IV [0:7] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   state_t      state, state_next;
   logic [31:0] m      [0:NUM_WORDS-1];
   logic [31:0] w      [0:15];   // w[0] is W[t]; window holds W[t..t+15]
   logic [31:0] v      [0:7];    // working variables a..h
   logic [31:0] digest [0:7];
   logic [5:0]  t;               // round index in ROUND, output index in OUTPUT
   logic        prev_start;

   logic        wr_en, msg_wr, start_wr, launch;
   logic [31:0] big_s0, big_s1, ch, maj, t1, t2, w_new;

   // Bus decode. A start only launches on its first cycle, so a held start fires once.
   always_comb begin
      wr_en    = bus.chipselect & bus.write;
      msg_wr   = wr_en && (int'(bus.address) < NUM_WORDS);
      start_wr = wr_en && (int'(bus.address) == START_ADDR);
      launch   = start_wr && !prev_start;
   end

   // One compression round plus the next schedule word W[t+16], which only
   // needs words already in the window.
   always_comb begin
      big_s1 = ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25);
      ch     = (v[4] & v[5]) ^ (~v[4] & v[6]);
      t1     = v[7] + big_s1 + ch + K[t] + w[0];
      big_s0 = ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22);
      maj    = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
      t2     = big_s0 + maj;
      w_new  = (ror(w[14], 17) ^ ror(w[14], 19) ^ (w[14] >> 10)) + w[9]
             + (ror(w[1], 7) ^ ror(w[1], 18) ^ (w[1] >> 3)) + w[0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (launch) state_next = ROUND;
         ROUND:   if (t == 6'd63) state_next = FINAL;
         FINAL:   state_next = OUTPUT;
         OUTPUT:  if (t == 6'd7) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_WORDS; i++) m[i] <= '0;
         for (int i = 0; i < 16; i++) w[i] <= '0;
         for (int i = 0; i < 8; i++) begin
            v[i]      <= '0;
            digest[i] <= '0;
         end
         t                <= '0;
         prev_start       <= 1'b0;
         bus.data_out     <= '0;
         bus.writeaddress <= '0;
      end else begin
         prev_start <= start_wr;
         if (state == IDLE && msg_wr) m[bus.address[AW-1:0]] <= bus.writedata;
         case (state)
            IDLE: begin
               if (launch) begin
                  for (int i = 0; i < 8; i++) v[i] <= IV[i];
                  for (int i = 0; i < 16; i++) w[i] <= m[i];
                  t <= '0;
               end
            end
            ROUND: begin
               v[0] <= t1 + t2;
               v[1] <= v[0];
               v[2] <= v[1];
               v[3] <= v[2];
               v[4] <= v[3] + t1;
               v[5] <= v[4];
               v[6] <= v[5];
               v[7] <= v[6];
               for (int i = 0; i < 15; i++) w[i] <= w[i+1];
               w[15] <= w_new;
               t     <= t + 6'd1;
            end
            FINAL: begin
               for (int i = 0; i < 8; i++) digest[i] <= IV[i] + v[i];
               t <= '0;
            end
            OUTPUT: begin
               bus.data_out     <= digest[t[2:0]];
               bus.writeaddress <= {1'b0, t[2:0]};
               t                <= t + 6'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_acc_top.sv
// tb/tb_sha256_acc_top.sv - directed self-checking bench for sha256_acc_top
module tb_sha256_acc_top;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   sha256_acc_top_if bus();

   sha256_acc_top #(.NUM_WORDS(16), .START_ADDR(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   localparam logic [511:0] KV_BLK = {
      32'h000000dc, 32'h00000000, 32'h3239b540, 32'h3339b233,
      32'h30b33239, 32'hb335b239, 32'hb5b239b5, 32'h39b0b533,
      32'h33353235, 32'hb530b5b6, 32'h30b335b2, 32'h35b239b5,
      32'h39b0b533, 32'h3239b0b3, 32'h00000000, 32'h000001bf
   };
   localparam logic [255:0] KV_DIG = {
      32'h80cab0c8, 32'hef5701ae, 32'hd57f628f, 32'hd04511fd,
      32'h4f2040ba, 32'h721acb80, 32'hc48650a4, 32'h677f47be
   };
   localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
   localparam logic [255:0] ABC_DIG = {
      32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
      32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
   };

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; holds the bus cycle for n clocks and returns at a negedge.
   task automatic bus_cycle(input logic cs, input logic we, input logic [4:0] addr,
                            input logic [31:0] data, input int n);
      bus.chipselect = cs;
      bus.write      = we;
      bus.address    = addr;
      bus.writedata  = data;
      repeat (n) @(negedge clk);
      bus.chipselect = 1'b0;
      bus.write      = 1'b0;
   endtask

   task automatic load_block(input logic [511:0] blk);
      logic [511:0] b;
      b = blk;
      for (int i = 0; i < 16; i++) bus_cycle(1'b1, 1'b1, 5'(i), b[511-32*i -: 32], 1);
   endtask

   // lead = posedges from the call until the edge that presents H0.
   task automatic expect_burst(input string name, input logic [255:0] dig, input int lead);
      logic [255:0] d;
      d = dig;
      repeat (lead) @(posedge clk);
      for (int k = 0; k < 8; k++) begin
         if (k != 0) @(posedge clk);
         #1;
         check($sformatf("%s data w%0d", name, k), bus.data_out, d[255-32*k -: 32]);
         check($sformatf("%s addr w%0d", name, k), {28'd0, bus.writeaddress}, 32'(k));
      end
   endtask

   initial begin
      logic seen;
      bus.chipselect = 1'b0;
      bus.write      = 1'b0;
      bus.address    = '0;
      bus.writedata  = '0;

      reset = 1'b1;
      #50;
      reset = 1'b0;
      #1;
      check("reset data_out", bus.data_out, 32'h0);
      check("reset writeaddress", {28'd0, bus.writeaddress}, 32'h0);

      // known vector, start written at E0 -> H0 at E66
      @(negedge clk);
      load_block(KV_BLK);
      bus_cycle(1'b1, 1'b1, 5'd16, 32'hffffffff, 1);
      expect_burst("kv", KV_DIG, 66);

      // "abc" with start held for three cycles
      @(negedge clk);
      load_block(ABC_BLK);
      bus_cycle(1'b1, 1'b1, 5'd16, 32'h0, 3);
      expect_burst("abc held", ABC_DIG, 64);

      // busy protection: message write and second start during rounds
      @(negedge clk);
      load_block(KV_BLK);
      bus_cycle(1'b1, 1'b1, 5'd16, 32'h0, 1);
      repeat (10) @(negedge clk);
      bus_cycle(1'b1, 1'b1, 5'd3, 32'h12345678, 1);
      bus_cycle(1'b1, 1'b1, 5'd16, 32'h0, 1);
      expect_burst("busy", KV_DIG, 54);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (bus.writeaddress !== 4'd7 || bus.data_out !== 32'h677f47be) seen = 1'b1;
      end
      check("busy single burst", {31'd0, seen}, 32'h0);

      // ignore gating: deselected write, non-write cycle, out-of-range address
      @(negedge clk);
      load_block(ABC_BLK);
      bus_cycle(1'b0, 1'b1, 5'd0, 32'hffffffff, 1);
      bus_cycle(1'b1, 1'b0, 5'd1, 32'hffffffff, 1);
      bus_cycle(1'b1, 1'b1, 5'd20, 32'hdeadbeef, 1);
      bus_cycle(1'b1, 1'b1, 5'd16, 32'h0, 1);
      expect_burst("gating", ABC_DIG, 66);

      // mid-hash reset after 30 rounds
      @(negedge clk);
      bus_cycle(1'b1, 1'b1, 5'd16, 32'h0, 1);
      repeat (30) @(negedge clk);
      reset = 1'b1;
      #1;
      check("midreset data_out", bus.data_out, 32'h0);
      check("midreset writeaddress", {28'd0, bus.writeaddress}, 32'h0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 90; i++) begin
         @(posedge clk);
         #1;
         if (bus.writeaddress !== 4'd0 || bus.data_out !== 32'h0) seen = 1'b1;
      end
      check("midreset no burst", {31'd0, seen}, 32'h0);

      // restart after reset with the block reloaded
      @(negedge clk);
      load_block(ABC_BLK);
      bus_cycle(1'b1, 1'b1, 5'd16, 32'h0, 1);
      expect_burst("restart", ABC_DIG, 66);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
